key_bcd_counter: RTL and testbench
==================================

# key_bcd_counter

Parametrised multi-digit BCD up/down event counter driven by raw push-button inputs. Each key is synchronised, optionally debounced, and edge-detected. Each press steps a DIGITS-wide packed BCD value up or down, or clears it, with wrap or saturate at the range limits. It sits between the board key pins and the seven-segment display driver, and replaces single-key, two-digit, undebounced counters.

## Interface
- DIGITS, 2, number of BCD digits; legal range 1..8; count range 0..10^DIGITS−1
- DB_CYCLES, 1000000, consecutive stable cycles for a debounced level change (20 ms at 50 MHz); legal ≥2; used only when debounce is compiled in
- WRAP, 1, 1 = wrap at the limits; 0 = saturate at the limits

Ports:
- clk  in  1  50 MHz system clock; all state is on the rising edge
- rst  in  1  synchronous, active-high reset
- key_up  in  1  raw key, high = pressed, asynchronous to clk
- key_down  in  1  raw key, high = pressed, asynchronous
- key_clr  in  1  raw key, high = pressed, asynchronous
- cnt_out  out  4*DIGITS  packed BCD; digit 0 (units) in [3:0], digit i in [4i+3:4i]
- ovf  out  1  one-cycle pulse on a wrap or on a blocked saturation attempt

## Operation
- Each key passes through a 2-flop synchroniser (sync1 → sync2) and is never used raw.
- Debounce per key, with DEBOUNCE_EN defined:
  - A counter increments on each cycle where sync2 ≠ stable, and clears when they are equal.
  - When sync2 ≠ stable and the counter equals DB_CYCLES−1, stable ← sync2 and the counter clears.
- Press event = stable & ~stable_prev, a one-cycle pulse per key. A release generates no event.
- Event priority in a single cycle:
  - clr: cnt_out ← 0, ovf stays 0, up/down in the same cycle are ignored.
  - up and down together (no clr): no change, ovf 0.
  - up alone: BCD increment. Digits at 9 roll to 0 and carry into the next digit; the carry out of the top digit means the count was at the maximum.
  - down alone: BCD decrement. Digits at 0 roll to 9 and borrow from the next digit.
- Limits with WRAP=1:
  - Max + up → 0, ovf=1.
  - 0 + down → max (all digits 9), ovf=1.
- Limits with WRAP=0:
  - Max + up → hold max, ovf=1.
  - 0 + down → hold 0, ovf=1.
- Every digit is always a valid BCD value (0–9); no non-BCD code ever appears on cnt_out.
- Reset clears sync flops, stable, stable_prev, debounce counters, cnt_out and ovf.
  - A key held through reset release is treated as a new press: it counts once after normal latency.

## Timing
- Reset values: cnt_out = 0, ovf = 0. Reset takes effect at the first rising edge with rst=1 and overrides any pending event, including mid-debounce.
- Let E0 be the first edge that samples a key high, with the key held stable afterwards.
  - With DEBOUNCE_EN: stable flips at E(1+DB_CYCLES); cnt_out updates at E(2+DB_CYCLES).
  - Without DEBOUNCE_EN: cnt_out updates at E2.
- ovf is high for exactly the cycle following the edge at which cnt_out takes its post-event value. It is a registered output in the same cycle as the new count.
- With debounce, any high pulse shorter than DB_CYCLES cycles on sync2 produces no event. A low glitch shorter than DB_CYCLES during a hold produces no second event.
- Maximum event rate: one per key per 2·DB_CYCLES cycles (press plus release) with debounce; one per 2 cycles without.

## Configuration
- Macro: KEY_BCD_COUNTER_DEBOUNCE_EN.
- Defined: the per-key debounce filter is built as described. DB_CYCLES is honoured.
- Undefined: stable = sync2 directly; no debounce counters are synthesised; DB_CYCLES is ignored; every sync2 rising edge is a press.
- Synchroniser, priority, BCD arithmetic and WRAP behaviour are identical in both builds.

## Test plan
Bench runs DIGITS=2, DB_CYCLES=4, macro defined, unless stated otherwise.
- Reset: assert rst 3 cycles with keys toggling → cnt_out=0x00 and ovf=0 throughout and after release.
- 12 clean up presses (hold 10 cycles, release 10) → cnt_out=0x12; first update lands exactly 6 edges after E0.
- Wrap with WRAP=1:
  - From 0x99, up → 0x00 with a 1-cycle ovf.
  - From 0x00, down → 0x99 with ovf.
  - Same tests with WRAP=0 → value holds 0x99 / 0x00 and ovf still pulses.
- Bounce: key_up high 3 cycles / low 2 cycles ×5, then high 10 cycles → exactly one increment. Repeat with the macro undefined → six increments.
- Simultaneous events:
  - up and down on the same cycle from 0x37 → stays 0x37, ovf=0.
  - clr with up from 0x37 → 0x00, ovf=0.
- DIGITS=3, 999 up presses from 0 → 0x999; next up → 0x000 with ovf. rst asserted mid-debounce → count 0; key still held after release → exactly one count.

Source files
------------

// File: rtl/key_bcd_counter.sv
// rtl/key_bcd_counter.sv - Multi-digit BCD up/down/clear key counter with optional debounce.
// Debounce filter is built when KEY_BCD_COUNTER_DEBOUNCE_EN is defined.
module key_bcd_counter #(
    parameter int DIGITS    = 2,
    parameter int DB_CYCLES = 1000000,
    parameter int WRAP      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_up,
    input  logic                  key_down,
    input  logic                  key_clr,
    output logic [4*DIGITS-1:0]   cnt_out,
    output logic                  ovf
);
    localparam int W = 4 * DIGITS;

    logic [2:0] keys;
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] stable;
    logic [2:0] stable_prev_q, stable_prev_d;
    logic [2:0] press;

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] inc_val, dec_val;
    logic         inc_carry, dec_borrow;

    // Bit order everywhere: 0 = up, 1 = down, 2 = clear.
    assign keys = {key_clr, key_down, key_up};

    always_comb begin
        sync1_d       = keys;
        sync2_d       = sync1_q;
        stable_prev_d = stable;
    end

`ifdef KEY_BCD_COUNTER_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES);

    logic [2:0]    stable_q, stable_d;
    logic [CW-1:0] db_cnt_q [3];
    logic [CW-1:0] db_cnt_d [3];

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            stable_d[k] = stable_q[k];
            db_cnt_d[k] = '0;
            if (sync2_q[k] != stable_q[k]) begin
                if (db_cnt_q[k] == CW'(DB_CYCLES - 1)) begin
                    stable_d[k] = sync2_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= '0;
            for (int k = 0; k < 3; k++) db_cnt_q[k] <= '0;
        end else begin
            stable_q <= stable_d;
            for (int k = 0; k < 3; k++) db_cnt_q[k] <= db_cnt_d[k];
        end
    end

    assign stable = stable_q;
`else
    assign stable = sync2_q;
`endif

    assign press = stable & ~stable_prev_q;

    // Ripple BCD increment/decrement; the carry/borrow out of the top digit flags a limit.
    always_comb begin
        inc_val   = cnt_q;
        dec_val   = cnt_q;
        inc_carry = 1'b1;
        dec_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_carry) begin
                if (cnt_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (cnt_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                    dec_borrow        = 1'b0;
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (press[2]) begin
            cnt_d = '0;
        end else if (press[0] && !press[1]) begin
            ovf_d = inc_carry;
            cnt_d = (inc_carry && WRAP == 0) ? cnt_q : inc_val;
        end else if (press[1] && !press[0]) begin
            ovf_d = dec_borrow;
            cnt_d = (dec_borrow && WRAP == 0) ? cnt_q : dec_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_prev_q <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_prev_q <= stable_prev_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
        end
    end

    assign cnt_out = cnt_q;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_key_bcd_counter.sv
// tb/tb_key_bcd_counter.sv - Directed self-checking bench for key_bcd_counter.
module tb_key_bcd_counter;
    localparam int DB = 4;
`ifdef KEY_BCD_COUNTER_DEBOUNCE_EN
    localparam int LAT    = DB + 2;
    localparam int BOUNCE = 1;
`else
    localparam int LAT    = 2;
    localparam int BOUNCE = 6;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_up = 1'b0, key_down = 1'b0, key_clr = 1'b0;
    logic [7:0]  cnt_a, cnt_b;
    logic [11:0] cnt_c;
    logic        ovf_a, ovf_b, ovf_c;
    int total = 0;
    int bad   = 0;
    int ovf_seen [3];

    always #5 clk = ~clk;

    // a: 2 digits wrap, b: 2 digits saturate, c: 3 digits wrap; all share the keys.
    key_bcd_counter #(.DIGITS(2), .DB_CYCLES(DB), .WRAP(1)) u_a (
        .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .key_clr(key_clr),
        .cnt_out(cnt_a), .ovf(ovf_a));
    key_bcd_counter #(.DIGITS(2), .DB_CYCLES(DB), .WRAP(0)) u_b (
        .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .key_clr(key_clr),
        .cnt_out(cnt_b), .ovf(ovf_b));
    key_bcd_counter #(.DIGITS(3), .DB_CYCLES(DB), .WRAP(1)) u_c (
        .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .key_clr(key_clr),
        .cnt_out(cnt_c), .ovf(ovf_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ovf_seen[0] += int'(ovf_a);
        ovf_seen[1] += int'(ovf_b);
        ovf_seen[2] += int'(ovf_c);
    endtask

    task automatic press(input logic u, input logic d, input logic c);
        ovf_seen = '{0, 0, 0};
        @(negedge clk);
        key_up = u; key_down = d; key_clr = c;
        repeat (10) step();
        @(negedge clk);
        key_up = 1'b0; key_down = 1'b0; key_clr = 1'b0;
        repeat (10) step();
    endtask

    task automatic chk_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic [11:0] ec, input int oa, input int ob, input int oc);
        chk({tag, "_cnt_a"}, 32'(cnt_a), 32'(ea));
        chk({tag, "_cnt_b"}, 32'(cnt_b), 32'(eb));
        chk({tag, "_cnt_c"}, 32'(cnt_c), 32'(ec));
        chk({tag, "_ovf_a"}, 32'(ovf_seen[0]), 32'(oa));
        chk({tag, "_ovf_b"}, 32'(ovf_seen[1]), 32'(ob));
        chk({tag, "_ovf_c"}, 32'(ovf_seen[2]), 32'(oc));
    endtask

    initial begin
        ovf_seen = '{0, 0, 0};
        // Reset held with keys toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {key_up, key_down, key_clr} = 3'($urandom);
            @(posedge clk); #1;
            chk("rst_cnt_a", 32'(cnt_a), 32'h0);
            chk("rst_ovf_a", 32'(ovf_a), 32'h0);
            chk("rst_cnt_c", 32'(cnt_c), 32'h0);
        end
        @(negedge clk);
        {key_up, key_down, key_clr} = 3'b000;
        rst = 1'b0;
        repeat (12) step();
        chk_all("post_rst", 8'h00, 8'h00, 12'h000, 0, 0, 0);

        // First press: exact latency from E0
        @(negedge clk);
        key_up = 1'b1;
        for (int e = 0; e <= LAT; e++) begin
            @(posedge clk); #1;
            if (e == LAT - 1) chk("lat_before", 32'(cnt_a), 32'h00);
            if (e == LAT)     chk("lat_at", 32'(cnt_a), 32'h01);
        end
        repeat (10 - LAT - 1) @(posedge clk);
        @(negedge clk);
        key_up = 1'b0;
        repeat (10) @(posedge clk);
        for (int i = 0; i < 11; i++) press(1'b1, 1'b0, 1'b0);
        chk_all("twelve", 8'h12, 8'h12, 12'h012, 0, 0, 0);

        // Up to 99, then the top limit
        for (int i = 0; i < 87; i++) press(1'b1, 1'b0, 1'b0);
        chk_all("at99", 8'h99, 8'h99, 12'h099, 0, 0, 0);
        press(1'b1, 1'b0, 1'b0);
        chk_all("up_max", 8'h00, 8'h99, 12'h100, 1, 1, 0);

        // Clear, then the bottom limit
        press(1'b0, 1'b0, 1'b1);
        chk_all("clr", 8'h00, 8'h00, 12'h000, 0, 0, 0);
        press(1'b0, 1'b1, 1'b0);
        chk_all("down_zero", 8'h99, 8'h00, 12'h999, 1, 1, 1);
        press(1'b1, 1'b0, 1'b0);
        chk_all("up_again", 8'h00, 8'h01, 12'h000, 1, 0, 1);

        // Bouncing key
        press(1'b0, 1'b0, 1'b1);
        ovf_seen = '{0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); key_up = 1'b1;
            repeat (3) step();
            @(negedge clk); key_up = 1'b0;
            repeat (2) step();
        end
        @(negedge clk); key_up = 1'b1;
        repeat (10) step();
        @(negedge clk); key_up = 1'b0;
        repeat (10) step();
        chk_all("bounce", 8'(BOUNCE), 8'(BOUNCE), 12'(BOUNCE), 0, 0, 0);

        // Simultaneous events from 37
        press(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 37; i++) press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        chk_all("up_down", 8'h37, 8'h37, 12'h037, 0, 0, 0);
        press(1'b1, 1'b0, 1'b1);
        chk_all("clr_up", 8'h00, 8'h00, 12'h000, 0, 0, 0);

        // Three-digit full range
        for (int i = 0; i < 999; i++) press(1'b1, 1'b0, 1'b0);
        chk("c999_cnt_c", 32'(cnt_c), 32'h999);
        chk("c999_cnt_a", 32'(cnt_a), 32'h99);
        press(1'b1, 1'b0, 1'b0);
        chk_all("c999_up", 8'h00, 8'h99, 12'h000, 1, 1, 1);

        // Reset during debounce with the key still held afterwards
        press(1'b1, 1'b0, 1'b0);
        chk("pre_mid_rst", 32'(cnt_c), 32'h001);
        @(negedge clk); key_up = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_cnt_c", 32'(cnt_c), 32'h000);
        chk("mid_rst_ovf_c", 32'(ovf_c), 32'h0);
        @(negedge clk); rst = 1'b0;
        ovf_seen = '{0, 0, 0};
        repeat (LAT + 6) step();
        @(negedge clk); key_up = 1'b0;
        repeat (10) step();
        chk_all("held_rst", 8'h01, 8'h01, 12'h001, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
